// File: rtl/chunked_seq_adder_if.sv
// Operand/result bundle for chunked_seq_adder; the ovf member exists only with CHUNK_ADDER_OVF_EN.
interface chunked_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef CHUNK_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, sub, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, sub, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/sub reusing one CHUNK-bit slice, LSB chunk first (ovf output with CHUNK_ADDER_OVF_EN).
// Latency: done pulses in the cycle after edge WIDTH/CHUNK; start is ignored while busy (no queuing).
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic              clk,
   input logic              rst,
   chunked_seq_adder_if.slave io
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] partial;
   logic             carry;
   logic [IW-1:0]    idx;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_chunk;
   logic [WIDTH-1:0] merged;

   always_comb begin
      a_chunk              = op_a[idx*CHUNK +: CHUNK];
      b_chunk              = op_b[idx*CHUNK +: CHUNK];
      {c_chunk, s_chunk}   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      merged               = partial;
      merged[idx*CHUNK +: CHUNK] = s_chunk;
   end

`ifdef CHUNK_ADDER_OVF_EN
   logic ovf_q;
   // Carry into the MSB is recovered as a ^ b ^ s at that bit, so this holds for any CHUNK.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && idx == IW'(N - 1)) begin
         ovf_q <= a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1] ^ c_chunk;
      end
   end
   assign io.ovf = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_a    <= '0;
         op_b    <= '0;
         partial <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (io.start) begin
                  op_a   <= io.a;
                  // Subtraction is a + ~b + 1; borrow-in inverts the injected carry.
                  op_b   <= io.sub ? ~io.b : io.b;
                  carry  <= io.sub ^ io.cin;
                  idx    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               partial[idx*CHUNK +: CHUNK] <= s_chunk;
               carry <= c_chunk;
               idx   <= idx + 1'b1;
               if (idx == IW'(N - 1)) begin
                  sum_q  <= merged;
                  cout_q <= c_chunk;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  idx    <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.busy = busy_q;
   assign io.done = done_q;
   assign io.sum  = sum_q;
   assign io.cout = cout_q;
endmodule
